// File: rtl/l2_ifill_arbiter_if.sv
// Bundle of the icache / non-cacheable fetch request ports, the L2 request and
// response channel, and the forwarded-response outputs of l2_ifill_arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface l2_ifill_arbiter_if #(
    parameter int ADDR_W = 40
);
    logic              ic_req_valid_i;
    logic [ADDR_W-1:0] ic_req_paddr_i;
    logic              ic_req_ready_o;
    logic              nc_req_valid_i;
    logic [ADDR_W-1:0] nc_req_paddr_i;
    logic              nc_req_ready_o;
    logic              ic_kill_i;
    logic              nc_kill_i;
    logic              l2_req_valid_o;
    logic              l2_req_ready_i;
    logic [ADDR_W-1:0] l2_req_paddr_o;
    logic              l2_req_nc_o;
    logic              l2_resp_valid_i;
    logic [63:0]       l2_resp_data_i;
    logic              ic_resp_valid_o;
    logic              ic_resp_last_o;
    logic              nc_grant_valid_o;
    logic [63:0]       resp_data_o;
    logic              busy_o;
    logic              spurious_o;

    modport slave (
        input  ic_req_valid_i, ic_req_paddr_i, nc_req_valid_i, nc_req_paddr_i,
        input  ic_kill_i, nc_kill_i, l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i,
        output ic_req_ready_o, nc_req_ready_o, l2_req_valid_o, l2_req_paddr_o,
        output l2_req_nc_o, ic_resp_valid_o, ic_resp_last_o, nc_grant_valid_o,
        output resp_data_o, busy_o, spurious_o
    );

    modport master (
        output ic_req_valid_i, ic_req_paddr_i, nc_req_valid_i, nc_req_paddr_i,
        output ic_kill_i, nc_kill_i, l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i,
        input  ic_req_ready_o, nc_req_ready_o, l2_req_valid_o, l2_req_paddr_o,
        input  l2_req_nc_o, ic_resp_valid_o, ic_resp_last_o, nc_grant_valid_o,
        input  resp_data_o, busy_o, spurious_o
    );
endinterface

// File: rtl/l2_ifill_arbiter.sv
// Round-robin arbiter between icache line refills and non-cacheable 8-byte
// fetches sharing one L2 request port. One transaction is in flight at a time;
// killed transactions still complete on the bus but their beats are swallowed.
module l2_ifill_arbiter #(
    parameter int ADDR_W   = 40,
    parameter int IC_BEATS = 4
) (
    input logic              clk_i,
    input logic              rstn_i,
    l2_ifill_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

    localparam int                OFF_W   = $clog2(IC_BEATS * 8);
    localparam logic [ADDR_W-1:0] IC_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] NC_MASK = ~ADDR_W'(7);
    localparam logic [2:0]        IC_LAST = 3'(IC_BEATS - 1);

    state_e            state_q, state_d;
    logic              owner_nc_q, owner_nc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              killed_q, killed_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_nc_q, last_nc_d;

    logic ic_ready, nc_ready, l2_valid, ic_fwd, nc_fwd, last_beat, spurious;
    logic owner_kill, final_beat;

    // Next-state and handshake/forwarding decode for the transaction FSM
    always_comb begin
        state_d    = state_q;
        owner_nc_d = owner_nc_q;
        addr_d     = addr_q;
        killed_d   = killed_q;
        cnt_d      = cnt_q;
        last_nc_d  = last_nc_q;
        ic_ready   = 1'b0;
        nc_ready   = 1'b0;
        l2_valid   = 1'b0;
        ic_fwd     = 1'b0;
        nc_fwd     = 1'b0;
        last_beat  = 1'b0;
        spurious   = 1'b0;
        owner_kill = owner_nc_q ? bus.nc_kill_i : bus.ic_kill_i;
        final_beat = owner_nc_q || (cnt_q == IC_LAST);

        unique case (state_q)
            IDLE: begin
                // Kills are meaningless here: nothing is owned yet.
                spurious = bus.l2_resp_valid_i;
                if (bus.ic_req_valid_i && (!bus.nc_req_valid_i || last_nc_q)) begin
                    ic_ready   = 1'b1;
                    state_d    = REQ;
                    owner_nc_d = 1'b0;
                    addr_d     = bus.ic_req_paddr_i;
                    last_nc_d  = 1'b0;
                    killed_d   = 1'b0;
                end else if (bus.nc_req_valid_i) begin
                    nc_ready   = 1'b1;
                    state_d    = REQ;
                    owner_nc_d = 1'b1;
                    addr_d     = bus.nc_req_paddr_i;
                    last_nc_d  = 1'b1;
                    killed_d   = 1'b0;
                end
            end
            REQ: begin
                // The request is never withdrawn; a kill only decides where we go after it.
                l2_valid = 1'b1;
                spurious = bus.l2_resp_valid_i;
                if (owner_kill) killed_d = 1'b1;
                if (bus.l2_req_ready_i) begin
                    cnt_d   = 3'd0;
                    state_d = (killed_q || owner_kill) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (bus.l2_resp_valid_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (!owner_kill) begin
                        ic_fwd    = !owner_nc_q;
                        nc_fwd    = owner_nc_q;
                        last_beat = !owner_nc_q && final_beat;
                    end
                    if (final_beat)      state_d = IDLE;
                    else if (owner_kill) state_d = DRAIN;
                end else if (owner_kill) begin
                    state_d = DRAIN;
                end
                if (owner_kill) killed_d = 1'b1;
            end
            DRAIN: begin
                if (bus.l2_resp_valid_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (final_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction state registers, abandoned immediately on reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            owner_nc_q <= 1'b0;
            addr_q     <= '0;
            killed_q   <= 1'b0;
            cnt_q      <= 3'd0;
            last_nc_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_nc_q <= owner_nc_d;
            addr_q     <= addr_d;
            killed_q   <= killed_d;
            cnt_q      <= cnt_d;
            last_nc_q  <= last_nc_d;
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign bus.ic_req_ready_o   = rstn_i & ic_ready;
    assign bus.nc_req_ready_o   = rstn_i & nc_ready;
    assign bus.l2_req_valid_o   = rstn_i & l2_valid;
    assign bus.l2_req_paddr_o   = addr_q & (owner_nc_q ? NC_MASK : IC_MASK);
    assign bus.l2_req_nc_o      = owner_nc_q;
    assign bus.ic_resp_valid_o  = rstn_i & ic_fwd;
    assign bus.ic_resp_last_o   = rstn_i & last_beat;
    assign bus.nc_grant_valid_o = rstn_i & nc_fwd;
    assign bus.resp_data_o      = bus.l2_resp_data_i;
    assign bus.busy_o           = rstn_i & (state_q != IDLE);
    assign bus.spurious_o       = rstn_i & spurious;
endmodule
